// File: rtl/ifu_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
// A response carrying an access fault is stored as INST_NOP with its error flag set.
package ifu_fetch_pkg;
  localparam int          DATA_WIDTH   = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic {
    IFU_IDLE = 1'b0,
    IFU_RUN  = 1'b1
  } ifu_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO (power-of-two depth) with flush and occupancy count.
// Data storage is not reset; only the pointers and the count are.
module ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (flush_i) begin
      do_push  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited word fetches, in-order response buffering,
// and redirect handling that flushes the buffer and drops in-flight responses.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  imem_err_i,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_err_o,
  input  logic                  inst_ready_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outst_q, outst_d, discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FW-1:0] fifo_wdata, fifo_rdata;
  logic [CW:0]   inflight;
  logic          gnt_fire, rsp_fire, rsp_keep;

  assign inflight    = {1'b0, fifo_count} + {1'b0, outst_q};
  assign imem_req_o  = (state_q == IFU_RUN) & ~redirect_i & (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign gnt_fire    = imem_req_o & imem_gnt_i;
  // a response with nothing outstanding (e.g. from before a reset) is ignored
  assign rsp_fire    = imem_rvalid_i & (outst_q != '0);
  assign rsp_keep    = rsp_fire & (discard_q == '0) & ~redirect_i;

  always_comb begin
    state_d   = (state_q == IFU_IDLE) ? IFU_RUN : state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    discard_d = discard_q;
    outst_d   = outst_q + CW'(gnt_fire) - CW'(rsp_fire);
    if (gnt_fire)                     pc_d      = pc_q + ADDR_WIDTH'(4);
    if (rsp_fire && discard_q != '0)  discard_d = discard_q - CW'(1);
    if (rsp_keep)                     resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
    // everything still in flight after this cycle belongs to the old stream
    if (redirect_i) begin
      pc_d      = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      resp_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      discard_d = outst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IFU_IDLE;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  assign fifo_push  = rsp_keep & (~fifo_full | fifo_pop);
  assign fifo_pop   = inst_valid_o & inst_ready_i & ~redirect_i;
  assign fifo_wdata = {imem_err_i, resp_pc_q, (imem_err_i ? INST_NOP : imem_rdata_i)};

  ifu_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // head fields read as reset values while the buffer is empty
  assign inst_valid_o = ~fifo_empty;
  assign inst_o       = fifo_empty ? INST_NOP : fifo_rdata[DATA_WIDTH-1:0];
  assign inst_pc_o    = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
  assign inst_err_o   = fifo_empty ? 1'b0 : fifo_rdata[FW-1];
endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: in-order memory model plus an expected-PC stream model.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0, imem_err_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0;
  logic        inst_valid_o, inst_err_o, inst_ready_i = 1'b0;
  logic [31:0] inst_o, inst_pc_o;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_err_o(inst_err_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] acc_q[$];
  int          cyc, vectors, miscompares;
  int          lat = 1, gnt_pct = 100, ready_pct = 100;
  bit          drv_rst, drv_redirect;
  logic [31:0] drv_rpc;
  logic [31:0] exp_fetch, exp_pc, prev_addr;
  bit          prev_redirect, prev_req_wait;
  bit          s_req, s_valid;
  bit          f8_seen, fc_seen, f8_err, fc_err;
  logic [31:0] f8_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a[5:2] == 4'h2);
  endfunction

  task automatic cycle();
    bit          rv;
    logic [31:0] exp_inst;
    @(negedge clk);
    rst_n         = drv_rst;
    rv            = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(mq[0].addr) : 32'h0;
    imem_err_i    = rv ? err_of(mq[0].addr) : 1'b0;
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    inst_ready_i  = ($urandom_range(99) < ready_pct);
    redirect_i    = drv_redirect;
    redirect_pc_i = drv_rpc;
    #2;
    s_req   = imem_req_o;
    s_valid = inst_valid_o;
    if (rst_n) begin
      if (prev_redirect) begin
        vectors++;
        if (inst_valid_o !== 1'b0) begin
          miscompares++; $display("FAIL valid_after_redirect: got %b want 0", inst_valid_o);
        end
      end
      if (redirect_i) begin
        vectors++;
        if (imem_req_o !== 1'b0) begin
          miscompares++; $display("FAIL req_during_redirect: got %b want 0", imem_req_o);
        end
      end
      if (prev_req_wait && !redirect_i) begin
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
          miscompares++;
          $display("FAIL req_stable: got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, prev_addr);
        end
      end
      vectors++;
      if (dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.pop_i) begin
        miscompares++; $display("FAIL fifo_overflow: got push into full want none");
      end
      if (imem_req_o && imem_gnt_i) begin
        vectors++;
        if (imem_addr_o !== exp_fetch) begin
          miscompares++; $display("FAIL fetch_addr: got %h want %h", imem_addr_o, exp_fetch);
        end
        mq.push_back('{addr: imem_addr_o, due: cyc + lat});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (inst_valid_o && inst_ready_i && !redirect_i) begin
        vectors++;
        exp_inst = err_of(exp_pc) ? INST_NOP : mem_word(exp_pc);
        if (inst_pc_o !== exp_pc || inst_o !== exp_inst || inst_err_o !== err_of(exp_pc)) begin
          miscompares++;
          $display("FAIL inst_stream: got pc=%h inst=%h err=%b want pc=%h inst=%h err=%b",
                   inst_pc_o, inst_o, inst_err_o, exp_pc, exp_inst, err_of(exp_pc));
        end
        acc_q.push_back(inst_pc_o);
        if (inst_pc_o == 32'h8000_0008) begin f8_seen = 1; f8_inst = inst_o; f8_err = inst_err_o; end
        if (inst_pc_o == 32'h8000_000C) begin fc_seen = 1; fc_err = inst_err_o; end
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_i) begin
        exp_fetch = {redirect_pc_i[31:2], 2'b00};
        exp_pc    = {redirect_pc_i[31:2], 2'b00};
      end
      if (rv) void'(mq.pop_front());
      prev_redirect = redirect_i;
      prev_req_wait = imem_req_o && !imem_gnt_i;
      prev_addr     = imem_addr_o;
    end else begin
      prev_redirect = 0;
      prev_req_wait = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    drv_rst = 0; drv_redirect = 0; drv_rpc = '0;
    lat = 1; gnt_pct = 100; ready_pct = 100;
    mq.delete();
    cycle(); cycle();
    exp_fetch = RST_PC; exp_pc = RST_PC;
    acc_q.delete();
    drv_rst = 1;
  endtask

  task automatic test_reset();
    drv_rst = 0;
    #1 rst_n = 1'b0;
    cycle();
    vectors++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RST_PC || inst_valid_o !== 1'b0 ||
        inst_o !== INST_NOP || inst_pc_o !== 32'h0 || inst_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got req=%b addr=%h v=%b inst=%h pc=%h err=%b", imem_req_o,
               imem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o);
    end
  endtask

  task automatic test_stream();
    int first_req = -1, first_val = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (first_req < 0 && s_req) first_req = i;
      if (first_val < 0 && s_valid) first_val = i;
    end
    vectors++;
    if (first_req != 1) begin
      miscompares++; $display("FAIL first_req_cycle: got %0d want 1", first_req);
    end
    vectors++;
    if (first_val != 3) begin
      miscompares++; $display("FAIL first_valid_cycle: got %0d want 3", first_val);
    end
    vectors++;
    if (acc_q.size() < 10 || acc_q[0] !== RST_PC) begin
      miscompares++; $display("FAIL stream_progress: got %0d insts want >=10 from %h", acc_q.size(), RST_PC);
    end
  endtask

  task automatic test_fault();
    vectors++;
    if (!f8_seen || f8_inst !== INST_NOP || f8_err !== 1'b1) begin
      miscompares++; $display("FAIL fault_inst: got seen=%b inst=%h err=%b want 1 %h 1", f8_seen, f8_inst, f8_err, INST_NOP);
    end
    vectors++;
    if (!fc_seen || fc_err !== 1'b0) begin
      miscompares++; $display("FAIL fault_next: got seen=%b err=%b want 1 0", fc_seen, fc_err);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready_pct = 0;
    for (int i = 0; i < 8; i++) cycle();
    vectors++;
    if (s_req !== 1'b0 || inst_valid_o !== 1'b1 || inst_pc_o !== RST_PC || dut.fifo_count !== 2'd2) begin
      miscompares++;
      $display("FAIL stall_hold: got req=%b v=%b pc=%h cnt=%0d want 0 1 %h 2", s_req, inst_valid_o,
               inst_pc_o, dut.fifo_count, RST_PC);
    end
    ready_pct = 100;
    for (int i = 0; i < 20; i++) cycle();
    vectors++;
    if (acc_q.size() < 6 || acc_q[0] !== RST_PC) begin
      miscompares++; $display("FAIL stall_release: got %0d insts want >=6 from %h", acc_q.size(), RST_PC);
    end
  endtask

  task automatic test_redirect();
    int n = 0;
    do_reset();
    lat = 3;
    cycle();
    while (mq.size() < 2 && n < 20) begin cycle(); n++; end
    drv_redirect = 1; drv_rpc = 32'h8000_0102;
    acc_q.delete();
    cycle();
    drv_redirect = 0;
    n = 0;
    while (acc_q.size() < 2 && n < 40) begin cycle(); n++; end
    vectors++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'h8000_0100 || acc_q[1] !== 32'h8000_0104) begin
      miscompares++; $display("FAIL redirect_target: got %0d insts want 8000_0100, 8000_0104", acc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    lat = 2;
    for (int i = 0; i < 4; i++) cycle();
    acc_q.delete();
    drv_redirect = 1; drv_rpc = 32'h8000_0200; cycle();
    drv_rpc = 32'h8000_0300; cycle();
    drv_redirect = 0;
    while (acc_q.size() < 1 && n < 40) begin cycle(); n++; end
    vectors++;
    if (acc_q.size() < 1 || acc_q[0] !== 32'h8000_0300) begin
      miscompares++; $display("FAIL back_to_back: got %0d insts want first 8000_0300", acc_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    gnt_pct = 60; ready_pct = 70;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(3, 1);
      drv_redirect = (i > 2) && ($urandom_range(99) < 8);
      drv_rpc      = 32'h8000_0000 | 32'($urandom_range(1023));
      cycle();
    end
    drv_redirect = 0;
    vectors++;
    if (acc_q.size() < 20) begin
      miscompares++; $display("FAIL random_progress: got %0d insts want >=20", acc_q.size());
    end
  endtask

  task automatic test_midreset();
    int n = 0;
    do_reset();
    lat = 3;
    cycle();
    while (mq.size() < 2 && n < 20) begin cycle(); n++; end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RST_PC || inst_valid_o !== 1'b0 ||
        inst_o !== INST_NOP || inst_pc_o !== 32'h0 || inst_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b addr=%h v=%b inst=%h pc=%h err=%b", imem_req_o,
               imem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o);
    end
    do_reset();
    for (int i = 0; i < 20; i++) cycle();
    vectors++;
    if (acc_q.size() < 4 || acc_q[0] !== RST_PC) begin
      miscompares++; $display("FAIL restart_pc: got %0d insts want first %h", acc_q.size(), RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fault();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
